regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_readport.sv | 41 ++++
 rtl/regfile_param.sv | 113 +++++++++++
 tb/tb_regfile_param.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: types and constants shared by the parameterised register file.
//   state_t       controller states (CLEAR zeroes storage, READY accepts writes)
//   DEF_WIDTH     default data bits per register
//   DEF_ADDR_BITS default address bits (DEPTH = 2**ADDR_BITS)
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_ADDR_BITS = 5;

endpackage

// File: rtl/regfile_readport.sv
// regfile_readport: one combinational read port of the register file.
// Ports:
//   regs       storage array snapshot (all registers)
//   read_addr  register selected by this port
//   busy       clear sequence running; forces read_data to zero
//   write_en   a write is being accepted this cycle (already gated by READY)
//   write_addr address of the write in flight
//   write_data data of the write in flight
//   read_data  selected register, write-through bypassed, zero-register aware
module regfile_readport
    import regfile_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int ZERO_REG  = 1
) (
    input  logic [WIDTH-1:0]     regs [2**ADDR_BITS],
    input  logic [ADDR_BITS-1:0] read_addr,
    input  logic                 busy,
    input  logic                 write_en,
    input  logic [ADDR_BITS-1:0] write_addr,
    input  logic [WIDTH-1:0]     write_data,
    output logic [WIDTH-1:0]     read_data
);

    // Priority, lowest to highest: stored value, same-cycle bypass,
    // hardwired zero register, clear/reset blanking.
    always_comb begin
        read_data = regs[read_addr];
        if (write_en && (read_addr == write_addr)) begin
            read_data = write_data;
        end
        if ((ZERO_REG != 0) && (read_addr == '0)) begin
            read_data = '0;
        end
        if (busy) begin
            read_data = '0;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// regfile_param: parameterised multi-read-port register file with a
// self-clearing controller. After reset release (or a Clear request) the
// controller zeroes one register per cycle; writes are ignored and reads
// return zero until every register has been cleared.
// Ports:
//   Clk           clock, all state on rising edge
//   ResetN        asynchronous active-low reset (control only, not storage)
//   Clear         synchronous request to restart the clear sequence
//   RegWrite      write enable
//   WriteRegister write address
//   WriteData     write data
//   ReadRegister  NREAD flattened read addresses, port k at [k*ADDR_BITS +: ADDR_BITS]
//   ReadData      NREAD flattened read data, port k at [k*WIDTH +: WIDTH]
//   Busy          high while the clear sequence runs
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int NREAD     = 2,
    parameter int ZERO_REG  = 1
) (
    input  logic                       Clk,
    input  logic                       ResetN,
    input  logic                       Clear,
    input  logic                       RegWrite,
    input  logic [ADDR_BITS-1:0]       WriteRegister,
    input  logic [WIDTH-1:0]           WriteData,
    input  logic [NREAD*ADDR_BITS-1:0] ReadRegister,
    output logic [NREAD*WIDTH-1:0]     ReadData,
    output logic                       Busy
);

    localparam int DEPTH = 2**ADDR_BITS;

    state_t               state;
    state_t               state_next;
    logic [ADDR_BITS-1:0] count;
    logic [ADDR_BITS-1:0] count_next;
    logic [WIDTH-1:0]     regs [DEPTH];
    logic                 write_ok;
    logic                 store_ok;

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            CLEAR: begin
                if (Clear) begin
                    count_next = '0;
                end else if (count == '1) begin
                    // Last register is zeroed on this edge.
                    state_next = READY;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            READY: begin
                if (Clear) begin
                    state_next = CLEAR;
                    count_next = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                count_next = '0;
            end
        endcase
    end

    // Busy is registered alongside the state so it always equals (state == CLEAR).
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state <= CLEAR;
            count <= '0;
            Busy  <= 1'b1;
        end else begin
            state <= state_next;
            count <= count_next;
            Busy  <= (state_next == CLEAR);
        end
    end

    assign write_ok = (state == READY) && RegWrite;
    assign store_ok = write_ok && !((ZERO_REG != 0) && (WriteRegister == '0));

    // Storage has no reset; it is zeroed only by the clear sequence.
    always_ff @(posedge Clk) begin
        if (state == CLEAR) begin
            regs[count] <= '0;
        end else if (store_ok) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        regfile_readport #(
            .WIDTH     (WIDTH),
            .ADDR_BITS (ADDR_BITS),
            .ZERO_REG  (ZERO_REG)
        ) u_port (
            .regs       (regs),
            .read_addr  (ReadRegister[k*ADDR_BITS +: ADDR_BITS]),
            .busy       (Busy),
            .write_en   (write_ok),
            .write_addr (WriteRegister),
            .write_data (WriteData),
            .read_data  (ReadData[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: self-checking bench for regfile_param. Two instances
// share all inputs: dut (register 0 hardwired to zero) and dut_nz (register 0
// ordinary). Table vectors cover writes, bypass and holds; hand sequences
// cover reset, clear, clear restart and reset during clear.
module tb_regfile_param;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic        Clear;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [9:0]  ReadRegister;
    logic [63:0] ReadData;
    logic [63:0] ReadData_nz;
    logic        Busy;
    logic        Busy_nz;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0][31:0] pre;
        logic [1:0][31:0] post;
        logic [1:0][31:0] nz_pre;
        logic [1:0][31:0] nz_post;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[9];

    regfile_param #(.WIDTH(32), .ADDR_BITS(5), .NREAD(2), .ZERO_REG(1)) dut (
        .Clk           (Clk),
        .ResetN        (ResetN),
        .Clear         (Clear),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister  (ReadRegister),
        .ReadData      (ReadData),
        .Busy          (Busy)
    );

    regfile_param #(.WIDTH(32), .ADDR_BITS(5), .NREAD(2), .ZERO_REG(0)) dut_nz (
        .Clk           (Clk),
        .ResetN        (ResetN),
        .Clear         (Clear),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister  (ReadRegister),
        .ReadData      (ReadData_nz),
        .Busy          (Busy_nz)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [31:0] value);
        exp_t e;
        e.name  = name;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] act);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard underflow: got %h, expected nothing", act);
        end else begin
            e = sb.pop_front();
            compare(e.name, act, e.value);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Counts edges until Busy drops, bounded at 100.
    task automatic wait_ready(output int n);
        n = 0;
        while (Busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] p0, input logic [31:0] p1,
                                input logic [31:0] q0, input logic [31:0] q1,
                                input logic [31:0] n0, input logic [31:0] n1,
                                input logic [31:0] m0, input logic [31:0] m1);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ra0 = ra0; v.ra1 = ra1;
        v.pre     = {p1, p0};
        v.post    = {q1, q0};
        v.nz_pre  = {n1, n0};
        v.nz_post = {m1, m0};
        return v;
    endfunction

    task automatic apply_vec(input int idx, input vec_t v);
        RegWrite      = v.we;
        WriteRegister = v.wa;
        WriteData     = v.wd;
        ReadRegister  = {v.ra1, v.ra0};
        push($sformatf("vec%0d pre p0", idx), v.pre[0]);
        push($sformatf("vec%0d pre p1", idx), v.pre[1]);
        push($sformatf("vec%0d pre nz p0", idx), v.nz_pre[0]);
        push($sformatf("vec%0d pre nz p1", idx), v.nz_pre[1]);
        #2;
        pop_check(ReadData[31:0]);
        pop_check(ReadData[63:32]);
        pop_check(ReadData_nz[31:0]);
        pop_check(ReadData_nz[63:32]);
        tick();
        RegWrite = 1'b0;
        push($sformatf("vec%0d post p0", idx), v.post[0]);
        push($sformatf("vec%0d post p1", idx), v.post[1]);
        push($sformatf("vec%0d post nz p0", idx), v.nz_post[0]);
        push($sformatf("vec%0d post nz p1", idx), v.nz_post[1]);
        #1;
        pop_check(ReadData[31:0]);
        pop_check(ReadData[63:32]);
        pop_check(ReadData_nz[31:0]);
        pop_check(ReadData_nz[63:32]);
    endtask

    task automatic read_pair(input string name, input logic [4:0] a0, input logic [4:0] a1,
                             input logic [31:0] e0, input logic [31:0] e1);
        ReadRegister = {a1, a0};
        #1;
        compare({name, " p0"}, ReadData[31:0], e0);
        compare({name, " p1"}, ReadData[63:32], e1);
    endtask

    initial begin
        int n;

        tbl[0] = mk(1'b1, 5'd2,  32'd42,        5'd2, 5'd2,
                    32'd42, 32'd42, 32'd42, 32'd42, 32'd42, 32'd42, 32'd42, 32'd42);
        tbl[1] = mk(1'b1, 5'd2,  32'd15,        5'd2, 5'd2,
                    32'd15, 32'd15, 32'd15, 32'd15, 32'd15, 32'd15, 32'd15, 32'd15);
        tbl[2] = mk(1'b0, 5'd2,  32'd16,        5'd2, 5'd2,
                    32'd15, 32'd15, 32'd15, 32'd15, 32'd15, 32'd15, 32'd15, 32'd15);
        tbl[3] = mk(1'b1, 5'd0,  32'hDEADBEEF,  5'd0, 5'd0,
                    32'd0, 32'd0, 32'd0, 32'd0,
                    32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        tbl[4] = mk(1'b1, 5'd5,  32'd7,         5'd5, 5'd6,
                    32'd7, 32'd0, 32'd7, 32'd0, 32'd7, 32'd0, 32'd7, 32'd0);
        tbl[5] = mk(1'b1, 5'd6,  32'h1234,      5'd5, 5'd6,
                    32'd7, 32'h1234, 32'd7, 32'h1234, 32'd7, 32'h1234, 32'd7, 32'h1234);
        tbl[6] = mk(1'b1, 5'd31, 32'hFFFFFFFF,  5'd31, 5'd0,
                    32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'd0,
                    32'hFFFFFFFF, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF);
        tbl[7] = mk(1'b0, 5'd0,  32'd5,         5'd0, 5'd31,
                    32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF,
                    32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF, 32'hFFFFFFFF);
        tbl[8] = mk(1'b1, 5'd7,  32'h0000A5A5,  5'd7, 5'd7,
                    32'hA5A5, 32'hA5A5, 32'hA5A5, 32'hA5A5,
                    32'hA5A5, 32'hA5A5, 32'hA5A5, 32'hA5A5);

        ResetN        = 1'b0;
        Clear         = 1'b0;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister  = {5'd3, 5'd1};

        // Held in reset: Busy high, reads blanked.
        tick();
        tick();
        compare("reset busy", {31'b0, Busy}, 32'd1);
        compare("reset busy nz", {31'b0, Busy_nz}, 32'd1);
        compare("reset read p0", ReadData[31:0], 32'd0);
        compare("reset read p1", ReadData[63:32], 32'd0);

        ResetN = 1'b1;
        wait_ready(n);
        compare("busy cycles after reset", n, 32'd32);
        compare("busy low after clear", {31'b0, Busy}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            read_pair($sformatf("cleared reg %0d", i), 5'(i), 5'(31 - i), 32'd0, 32'd0);
        end

        for (int i = 0; i < 9; i++) begin
            apply_vec(i, tbl[i]);
        end

        // Clear pulse with a write attempted while busy.
        RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'd9;
        tick();
        RegWrite = 1'b0;
        read_pair("reg3 before clear", 5'd3, 5'd3, 32'd9, 32'd9);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        compare("busy after clear pulse", {31'b0, Busy}, 32'd1);
        RegWrite = 1'b1; WriteRegister = 5'd4; WriteData = 32'd11;
        ReadRegister = {5'd4, 5'd4};
        #1;
        compare("busy read blank p0", ReadData[31:0], 32'd0);
        compare("busy read blank p1", ReadData[63:32], 32'd0);
        wait_ready(n);
        RegWrite = 1'b0;
        compare("busy cycles after clear", n, 32'd32);
        read_pair("after clear reg3/reg4", 5'd3, 5'd4, 32'd0, 32'd0);
        read_pair("after clear reg2/reg7", 5'd2, 5'd7, 32'd0, 32'd0);

        // Clear again while already clearing restarts the count.
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        wait_ready(n);
        compare("busy cycles after clear restart", n, 32'd32);

        // Reset asserted at clear cycle 10 restarts the full sequence.
        RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'd9;
        tick();
        RegWrite = 1'b0;
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        ResetN = 1'b0;
        #1;
        compare("busy during mid-clear reset", {31'b0, Busy}, 32'd1);
        ReadRegister = {5'd3, 5'd3};
        #1;
        compare("read during mid-clear reset", ReadData[31:0], 32'd0);
        ResetN = 1'b1;
        wait_ready(n);
        compare("busy cycles after mid-clear reset", n, 32'd32);
        read_pair("after reset reg3/reg4", 5'd3, 5'd4, 32'd0, 32'd0);

        compare("scoreboard empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
